mem_arbiter: RTL and testbench

- Sits directly downstream of the processor core, between its instruction-cache and data-cache miss ports and the single external memory port.
- Arbitrates line-fill reads from the icache and line reads/writebacks from the dcache.
- Splits each line into BEATS memory beats and reassembles read beats into a full line.
- Returns one response per request, carrying the full line for reads and a one-cycle acknowledge for writes.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between icache and dcache line requests onto one beat-wide
// memory port: splits lines into beats and reassembles read beats into a line.
module mem_arbiter #(
  parameter  int ADDR_W = 36,
  parameter  int BEAT_W = 128,
  parameter  int BEATS  = 4,
  localparam int LINE_W = BEAT_W * BEATS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_resp_valid,
  output logic [LINE_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [LINE_W-1:0] d_resp_data,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              err
);
  localparam int CW   = $clog2(BEATS) + 1;
  localparam int IW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF  = $clog2(LINE_W / 8);
  localparam int BOFF = $clog2(BEAT_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, RESP = 2'd3} state_t;

  state_t                       state_r, state_s;
  logic [ADDR_W-1:0]            addr_r;
  logic                         we_r, gnt_d_r, last_d_r, err_r;
  logic [BEATS-1:0][BEAT_W-1:0] wbuf_r, rbuf_r, rbuf_s, i_data_r, d_data_r;
  logic [CW-1:0]                issue_cnt_r, ret_cnt_r, issue_nxt_s, ret_nxt_s;
  logic                         gnt_i_s, gnt_d_s, hs_s, accept_s, ret_ok_s;

  // Grant selection, beat accounting and next-state decode
  always_comb begin
    gnt_i_s  = 1'b0;
    gnt_d_s  = 1'b0;
    rbuf_s   = rbuf_r;
    state_s  = state_r;
    if (state_r == IDLE) begin
      // last_d_r high means the dcache won last, so the icache wins a tie
      gnt_i_s = i_req_valid & (~d_req_valid | last_d_r);
      gnt_d_s = d_req_valid & ~gnt_i_s;
    end else begin
      gnt_i_s = 1'b0;
      gnt_d_s = 1'b0;
    end
    hs_s        = gnt_i_s | gnt_d_s;
    accept_s    = (state_r == ISSUE) & mem_ready;
    ret_ok_s    = mem_rvalid & ~we_r & ((state_r == ISSUE) | (state_r == DRAIN)) &
                  (ret_cnt_r < CW'(BEATS));
    issue_nxt_s = issue_cnt_r + CW'(accept_s);
    ret_nxt_s   = ret_cnt_r + CW'(ret_ok_s);
    if (ret_ok_s) begin
      rbuf_s[ret_cnt_r[IW-1:0]] = mem_rdata;
    end else begin
      rbuf_s = rbuf_r;
    end
    case (state_r)
      IDLE: begin
        if (hs_s) state_s = ISSUE;
        else      state_s = IDLE;
      end
      ISSUE: begin
        if (issue_nxt_s == CW'(BEATS)) begin
          if (we_r || (ret_nxt_s == CW'(BEATS))) state_s = RESP;
          else                                   state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (ret_nxt_s == CW'(BEATS)) state_s = RESP;
        else                         state_s = DRAIN;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, captured request, beat counters, line buffers and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      we_r        <= 1'b0;
      gnt_d_r     <= 1'b0;
      last_d_r    <= 1'b0;
      err_r       <= 1'b0;
      wbuf_r      <= '0;
      rbuf_r      <= '0;
      i_data_r    <= '0;
      d_data_r    <= '0;
      issue_cnt_r <= '0;
      ret_cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      rbuf_r  <= rbuf_s;
      err_r   <= err_r | (mem_rvalid & ~ret_ok_s);
      if (hs_s) begin
        addr_r      <= (gnt_d_s ? d_req_addr : i_req_addr) & LINE_MASK;
        we_r        <= gnt_d_s & d_req_we;
        gnt_d_r     <= gnt_d_s;
        last_d_r    <= gnt_d_s;
        issue_cnt_r <= '0;
        ret_cnt_r   <= '0;
        if (gnt_d_s) wbuf_r <= d_req_wdata;
      end else begin
        issue_cnt_r <= issue_nxt_s;
        ret_cnt_r   <= ret_nxt_s;
      end
      // rbuf_s already holds a final beat returning on the same edge
      if ((state_s == RESP) && !we_r) begin
        if (gnt_d_r) d_data_r <= rbuf_s;
        else         i_data_r <= rbuf_s;
      end
    end
  end

  assign i_req_ready  = gnt_i_s;
  assign d_req_ready  = gnt_d_s;
  assign mem_valid    = (state_r == ISSUE);
  assign mem_we       = mem_valid & we_r;
  assign mem_addr     = mem_valid ? (addr_r + (ADDR_W'(issue_cnt_r) << BOFF)) : '0;
  assign mem_wdata    = mem_valid ? wbuf_r[issue_cnt_r[IW-1:0]] : '0;
  assign i_resp_valid = (state_r == RESP) & ~gnt_d_r;
  assign d_resp_valid = (state_r == RESP) & gnt_d_r;
  assign i_resp_data  = i_data_r;
  assign d_resp_data  = d_data_r;
  assign err          = err_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int ADDR_W = 36;
  localparam int BEAT_W = 128;
  localparam int BEATS  = 4;
  localparam int LINE_W = BEAT_W * BEATS;
  localparam logic [ADDR_W-1:0] LMASK = ~36'h3F;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req_valid, i_req_ready, i_resp_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic [LINE_W-1:0] i_resp_data;
  logic              d_req_valid, d_req_we, d_req_ready, d_resp_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic [LINE_W-1:0] d_req_wdata, d_resp_data;
  logic              mem_valid, mem_we, mem_ready, mem_rvalid, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  int n_cmp = 0, n_bad = 0, cyc_n = 0;
  // transaction-level model
  bit busy, cur_d, cur_we, last_d, err_exp;
  logic [ADDR_W-1:0] cur_base, first_addr;
  logic [LINE_W-1:0] cur_wdata, cur_rline, exp_i, exp_d;
  int acc_n, ret_n, hs_cyc, done_cyc, last_lat, last_due, n_iresp, n_dresp;
  int ret_due[$];
  logic [BEAT_W-1:0] ret_dat[$];
  bit rdy_q[$], hs_order[$];
  bit rdy_rand, auto_req, small_data, inject_rv, i_hs_prev, d_hs_prev;
  int lat_min, lat_max;

  typedef struct {
    bit is_d; bit we; bit sd;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [ADDR_W-1:0] exp_base;
    int exp_lat;
    logic [LINE_W-1:0] exp_line;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] beat_data(input logic [ADDR_W-1:0] a, input int idx);
    if (small_data) return BEAT_W'(8'hA0) + BEAT_W'(idx);
    return {20'hA5A5A, a, ~a, a ^ 36'h123456789};
  endfunction

  function automatic logic [LINE_W-1:0] hash_line(input logic [ADDR_W-1:0] base);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < BEATS; k++)
      l[k*BEAT_W +: BEAT_W] = {20'hA5A5A, base + ADDR_W'(k*16), ~(base + ADDR_W'(k*16)),
                               (base + ADDR_W'(k*16)) ^ 36'h123456789};
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc();
    bit gi, gd, mv_e, ir_e, dr_e, from_q, rv_ok;
    int due;
    if (i_hs_prev) begin i_req_valid = 1'b0; i_hs_prev = 1'b0; end
    if (d_hs_prev) begin d_req_valid = 1'b0; d_hs_prev = 1'b0; end
    if (auto_req) begin
      if (!i_req_valid && $urandom_range(2, 0) == 0) begin
        i_req_valid = 1'b1;
        i_req_addr  = {4'($urandom_range(15, 0)), 32'($urandom)};
      end
      if (!d_req_valid && $urandom_range(2, 0) == 0) begin
        d_req_valid = 1'b1;
        d_req_we    = 1'($urandom_range(1, 0));
        d_req_addr  = {4'($urandom_range(15, 0)), 32'($urandom)};
        d_req_wdata = rnd_line();
      end
    end
    if (rdy_q.size() > 0) mem_ready = rdy_q.pop_front();
    else if (rdy_rand)    mem_ready = 1'($urandom_range(1, 0));
    else                  mem_ready = 1'b1;
    from_q     = (ret_due.size() > 0) && (ret_due[0] <= cyc_n);
    mem_rvalid = from_q | inject_rv;
    mem_rdata  = from_q ? ret_dat[0] : {$urandom, $urandom, $urandom, $urandom};
    inject_rv  = 1'b0;
    #1;
    gi   = !busy && i_req_valid && (!d_req_valid || last_d);
    gd   = !busy && d_req_valid && !gi;
    mv_e = busy && (cyc_n > hs_cyc) && (acc_n < BEATS);
    ir_e = busy && (done_cyc >= 0) && (cyc_n == done_cyc + 1) && !cur_d;
    dr_e = busy && (done_cyc >= 0) && (cyc_n == done_cyc + 1) && cur_d;
    chk("i_req_ready", i_req_ready, gi);
    chk("d_req_ready", d_req_ready, gd);
    chk("mem_valid", mem_valid, mv_e);
    if (mv_e) begin
      chk("mem_addr", mem_addr, cur_base + ADDR_W'(acc_n*16));
      chk("mem_we", mem_we, cur_we);
      if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata[acc_n*BEAT_W +: BEAT_W]);
    end
    if (ir_e) exp_i = cur_rline;
    if (dr_e && !cur_we) exp_d = cur_rline;
    chk("i_resp_valid", i_resp_valid, ir_e);
    chk("d_resp_valid", d_resp_valid, dr_e);
    chk("i_resp_data", i_resp_data, exp_i);
    chk("d_resp_data", d_resp_data, exp_d);
    chk("err", err, err_exp);
    if (i_req_valid && i_req_ready) hs_order.push_back(1'b0);
    if (d_req_valid && d_req_ready) hs_order.push_back(1'b1);
    if (mv_e && mem_ready) begin
      if (acc_n == 0) first_addr = mem_addr;
      if (!cur_we) begin
        due = cyc_n + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ret_due.push_back(due);
        ret_dat.push_back(beat_data(cur_base + ADDR_W'(acc_n*16), acc_n));
      end
      acc_n++;
    end
    rv_ok = busy && (cyc_n > hs_cyc) && (done_cyc < 0) && !cur_we && (ret_n < BEATS);
    if (mem_rvalid) begin
      if (rv_ok) begin
        cur_rline[ret_n*BEAT_W +: BEAT_W] = mem_rdata;
        ret_n++;
      end else begin
        err_exp = 1'b1;
      end
      if (from_q) begin
        void'(ret_due.pop_front());
        void'(ret_dat.pop_front());
      end
    end
    if (ir_e || dr_e) begin
      busy = 1'b0;
      last_lat = cyc_n - hs_cyc;
      if (ir_e) n_iresp++;
      else      n_dresp++;
    end
    if (busy && (done_cyc < 0) && (acc_n == BEATS) && (cur_we || ret_n == BEATS)) done_cyc = cyc_n;
    if (gi || gd) begin
      busy = 1'b1; hs_cyc = cyc_n; cur_d = gd; last_d = gd;
      acc_n = 0; ret_n = 0; done_cyc = -1; cur_rline = '0;
      if (gd) begin
        cur_we = d_req_we; cur_base = d_req_addr & LMASK; cur_wdata = d_req_wdata; d_hs_prev = 1'b1;
      end else begin
        cur_we = 1'b0; cur_base = i_req_addr & LMASK; i_hs_prev = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic run_idle(input int max_c);
    int k = 0;
    while ((busy || i_req_valid || d_req_valid) && k < max_c) begin
      cyc();
      k++;
    end
    n_cmp++;
    if (busy || i_req_valid || d_req_valid) begin
      n_bad++;
      $display("FAIL timeout: transaction still open after %0d cycles", max_c);
    end
  endtask

  task automatic do_reset();
    i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst i_req_ready", i_req_ready, 1'b0);
    chk("rst d_req_ready", d_req_ready, 1'b0);
    chk("rst i_resp_valid", i_resp_valid, 1'b0);
    chk("rst d_resp_valid", d_resp_valid, 1'b0);
    chk("rst i_resp_data", i_resp_data, '0);
    chk("rst d_resp_data", d_resp_data, '0);
    chk("rst mem_valid", mem_valid, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_addr", mem_addr, '0);
    chk("rst mem_wdata", mem_wdata, '0);
    chk("rst err", err, 1'b0);
    busy = 1'b0; last_d = 1'b0; err_exp = 1'b0; exp_i = '0; exp_d = '0;
    ret_due.delete(); ret_dat.delete(); rdy_q.delete(); last_due = 0;
    i_hs_prev = 1'b0; d_hs_prev = 1'b0; inject_rv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    auto_req = 1'b0; rdy_rand = 1'b0; small_data = 1'b0; lat_min = 1; lat_max = 1;
    n_iresp = 0; n_dresp = 0; hs_cyc = 0; done_cyc = -1; acc_n = 0; ret_n = 0;
    i_req_addr = '0; d_req_addr = '0; d_req_wdata = '0; mem_rdata = '0;
    rst_n = 1'b1;
    #2;
    do_reset();

    tbl[0] = '{1'b0, 1'b0, 1'b1, 36'h000000047, '0, 36'h40, 6,
               {128'hA3, 128'hA2, 128'hA1, 128'hA0}};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 36'h100, {128'hD3, 128'hD2, 128'hD1, 128'hD0}, 36'h100, 5, '0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 36'h1FF, '0, 36'h1C0, 6,
               {128'hA3, 128'hA2, 128'hA1, 128'hA0}};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 36'hFFFFFFFFF, '0, 36'hFFFFFFFC0, 6, hash_line(36'hFFFFFFFC0)};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 36'h23, rnd_line(), 36'h0, 5,
               {128'hA3, 128'hA2, 128'hA1, 128'hA0}};
    for (int k = 0; k < 5; k++) begin
      small_data = tbl[k].sd;
      if (tbl[k].is_d) begin
        d_req_valid = 1'b1; d_req_we = tbl[k].we; d_req_addr = tbl[k].addr; d_req_wdata = tbl[k].wdata;
      end else begin
        i_req_valid = 1'b1; i_req_addr = tbl[k].addr;
      end
      run_idle(30);
      chk("tbl first beat addr", first_addr, tbl[k].exp_base);
      chk("tbl latency", last_lat, tbl[k].exp_lat);
      chk("tbl resp line", tbl[k].is_d ? d_resp_data : i_resp_data, tbl[k].exp_line);
      cyc();
    end
    small_data = 1'b0;

    // simultaneous requests after reset: D, then I, then D on the next tie
    do_reset();
    hs_order.delete();
    i_req_valid = 1'b1; i_req_addr = 36'h200;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 36'h300;
    run_idle(60);
    i_req_valid = 1'b1; i_req_addr = 36'h240;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 36'h340; d_req_wdata = rnd_line();
    run_idle(60);
    chk("tie handshake count", hs_order.size(), 4);
    chk("tie first is D", hs_order[0], 1'b1);
    chk("tie second is I", hs_order[1], 1'b0);
    chk("tie third is D", hs_order[2], 1'b1);

    // mem_ready pattern 1,0,0,1 with returns two cycles after accept
    lat_min = 2; lat_max = 2;
    for (int k = 0; k < 5; k++) begin
      rdy_q.push_back(1'b1); rdy_q.push_back(1'b0); rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    end
    n0 = n_iresp;
    i_req_valid = 1'b1; i_req_addr = 36'h480;
    run_idle(60);
    chk("toggle resp count", n_iresp - n0, 1);
    rdy_q.delete();

    // reset after two beats of a read, then a fresh request
    lat_min = 1; lat_max = 1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 36'h600;
    for (int k = 0; k < 20 && acc_n < 2; k++) cyc();
    do_reset();
    n0 = n_dresp;
    repeat (4) cyc();
    chk("no resp after abort", n_dresp - n0, 0);
    n0 = n_iresp;
    i_req_valid = 1'b1; i_req_addr = 36'h700;
    run_idle(30);
    chk("fresh read after reset", n_iresp - n0, 1);

    // stray return in IDLE sets sticky err; a read still completes
    inject_rv = 1'b1;
    cyc();
    cyc();
    n0 = n_dresp;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 36'h840;
    run_idle(30);
    chk("read after err", n_dresp - n0, 1);
    chk("err sticky", err, 1'b1);

    // randomized traffic
    do_reset();
    auto_req = 1'b1; rdy_rand = 1'b1; lat_min = 1; lat_max = 4;
    repeat (3000) cyc();
    auto_req = 1'b0;
    run_idle(300);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
